axicb_grant_return_router: RTL and testbench

Response-side companion of the crossbar round-robin arbiter. It records the one-hot grant of every request accepted on a shared slave channel in an in-order FIFO. It then routes the corresponding response stream (e.g. R or B) back to the originating requester, popping one entry per completed response (last beat). It sits between a slave port's response channel and the REQ_NB master-side response interfaces.

---
 rtl/axicb_grant_return_router_if.sv | 27 ++
 rtl/axicb_grant_return_router.sv | 65 ++++++
 tb/tb_axicb_grant_return_router.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/axicb_grant_return_router_if.sv
// Grant-push and response-routing signals between the arbiter, the slave
// response channel and the per-requester response ports.
interface axicb_grant_return_router_if #(
    parameter int unsigned REQ_NB = 4,
    parameter int unsigned DATA_W = 64
);
    logic              push_valid;
    logic [REQ_NB-1:0] push_grant;
    logic              push_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_last;
    logic [DATA_W-1:0] rsp_data;
    logic [REQ_NB-1:0] m_rsp_valid;
    logic [REQ_NB-1:0] m_rsp_ready;
    logic [DATA_W-1:0] m_rsp_data;

    modport slave (
        input  push_valid, push_grant, rsp_valid, rsp_last, rsp_data, m_rsp_ready,
        output push_ready, rsp_ready, m_rsp_valid, m_rsp_data
    );

    modport master (
        output push_valid, push_grant, rsp_valid, rsp_last, rsp_data, m_rsp_ready,
        input  push_ready, rsp_ready, m_rsp_valid, m_rsp_data
    );
endinterface

// File: rtl/axicb_grant_return_router.sv
// In-order FIFO of one-hot grants; the head entry steers the shared response
// stream back to its requester and is popped on the last beat.
module axicb_grant_return_router #(
    parameter int unsigned REQ_NB = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       srst,
    axicb_grant_return_router_if.slave bus,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       orphan
);
    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    logic [DEPTH-1:0][REQ_NB-1:0] mem;
    ptr_t              wr_ptr, rd_ptr;
    logic              empty, full, push_fire, pop_fire;
    logic [REQ_NB-1:0] head, hit;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign bus.push_ready = !full;
    assign push_fire      = bus.push_valid && !full && (|bus.push_grant);
    assign pop_fire       = bus.rsp_valid && bus.rsp_ready && bus.rsp_last;

    // Head is one-hot, so the beat is taken only if its owner is ready.
    for (genvar i = 0; i < REQ_NB; i++) begin : g_lane
        assign bus.m_rsp_valid[i] = bus.rsp_valid & head[i];
        assign hit[i]             = head[i] & bus.m_rsp_ready[i];
    end

    assign bus.rsp_ready  = !empty && (|hit);
    assign bus.m_rsp_data = bus.rsp_data;
    assign outstanding    = wr_ptr - rd_ptr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            orphan <= 1'b0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            orphan <= 1'b0;
        end else begin
            if (push_fire)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop_fire)
                rd_ptr <= rd_ptr + ptr_t'(1);
            if (bus.rsp_valid && empty)
                orphan <= 1'b1;
        end
    end

    // Entries are qualified by the pointers, so the array needs no reset.
    always_ff @(posedge aclk) begin
        if (push_fire)
            mem[wr_ptr[AW-1:0]] <= bus.push_grant;
    end
endmodule

// File: tb/tb_axicb_grant_return_router.sv
// Directed vector bench for axicb_grant_return_router (REQ_NB=4, DEPTH=4).
module tb_axicb_grant_return_router;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic srst = 1'b0;
    logic [2:0]  outstanding;
    logic        orphan;
    logic [63:0] data_drv;
    int n_vec = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    axicb_grant_return_router_if #(.REQ_NB(4), .DATA_W(64)) bus ();

    axicb_grant_return_router #(.REQ_NB(4), .DEPTH(4), .DATA_W(64)) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus),
        .outstanding(outstanding), .orphan(orphan)
    );

    typedef struct {
        string      name;
        logic       srst;
        logic       pv;
        logic [3:0] pg;
        logic       rv;
        logic       rl;
        logic [3:0] mr;
        logic       e_pr;
        logic       e_rr;
        logic [3:0] e_mv;
        logic [2:0] e_out;
        logic       e_orph;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string name, logic s, logic pv, logic [3:0] pg, logic rv,
                                logic rl, logic [3:0] mr, logic e_pr, logic e_rr,
                                logic [3:0] e_mv, logic [2:0] e_out, logic e_orph);
        vec_t v;
        v.name = name; v.srst = s; v.pv = pv; v.pg = pg; v.rv = rv; v.rl = rl; v.mr = mr;
        v.e_pr = e_pr; v.e_rr = e_rr; v.e_mv = e_mv; v.e_out = e_out; v.e_orph = e_orph;
        vq.push_back(v);
    endfunction

    task automatic drive(logic s, logic pv, logic [3:0] pg, logic rv, logic rl, logic [3:0] mr);
        srst            = s;
        bus.push_valid  = pv;
        bus.push_grant  = pg;
        bus.rsp_valid   = rv;
        bus.rsp_last    = rl;
        bus.m_rsp_ready = mr;
        data_drv        = {$urandom, $urandom};
        bus.rsp_data    = data_drv;
    endtask

    task automatic check(string name, logic e_pr, logic e_rr, logic [3:0] e_mv,
                         logic [2:0] e_out, logic e_orph);
        n_vec++;
        if (bus.push_ready !== e_pr || bus.rsp_ready !== e_rr || bus.m_rsp_valid !== e_mv ||
            outstanding !== e_out || orphan !== e_orph || bus.m_rsp_data !== data_drv) begin
            n_bad++;
            $display("FAIL %s: got pr=%b rr=%b mv=%b out=%0d orph=%b data=%h, want pr=%b rr=%b mv=%b out=%0d orph=%b data=%h",
                     name, bus.push_ready, bus.rsp_ready, bus.m_rsp_valid, outstanding, orphan,
                     bus.m_rsp_data, e_pr, e_rr, e_mv, e_out, e_orph, data_drv);
        end
    endtask

    initial begin
        //   name          s  pv pg      rv rl mr      pr rr mv      out orph
        add("reset",       0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
        add("push0100",    0, 1, 4'b0100, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
        add("rsp0100",     0, 0, 4'b0000, 1, 1, 4'b1111, 1, 1, 4'b0100, 1, 0);
        add("idle_a",      0, 0, 4'b0000, 0, 0, 4'b1111, 1, 0, 4'b0000, 0, 0);
        add("push0001",    0, 1, 4'b0001, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
        add("push1000",    0, 1, 4'b1000, 0, 0, 4'b0000, 1, 0, 4'b0000, 1, 0);
        add("push0010",    0, 1, 4'b0010, 0, 0, 4'b0000, 1, 0, 4'b0000, 2, 0);
        add("b2_0001_0",   0, 0, 4'b0000, 1, 0, 4'b1111, 1, 1, 4'b0001, 3, 0);
        add("b2_0001_1",   0, 0, 4'b0000, 1, 1, 4'b1111, 1, 1, 4'b0001, 3, 0);
        add("b2_1000_0",   0, 0, 4'b0000, 1, 0, 4'b1111, 1, 1, 4'b1000, 2, 0);
        add("b2_1000_1",   0, 0, 4'b0000, 1, 1, 4'b1111, 1, 1, 4'b1000, 2, 0);
        add("b2_0010_0",   0, 0, 4'b0000, 1, 0, 4'b1111, 1, 1, 4'b0010, 1, 0);
        add("b2_0010_1",   0, 0, 4'b0000, 1, 1, 4'b1111, 1, 1, 4'b0010, 1, 0);
        add("idle_b",      0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
        add("fill0",       0, 1, 4'b0001, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
        add("fill1",       0, 1, 4'b0010, 0, 0, 4'b0000, 1, 0, 4'b0000, 1, 0);
        add("fill2",       0, 1, 4'b0100, 0, 0, 4'b0000, 1, 0, 4'b0000, 2, 0);
        add("fill3",       0, 1, 4'b1000, 0, 0, 4'b0000, 1, 0, 4'b0000, 3, 0);
        add("push_full",   0, 1, 4'b0001, 0, 0, 4'b0000, 0, 0, 4'b0000, 4, 0);
        add("full_hold",   0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4, 0);
        add("pop_full",    0, 1, 4'b1000, 1, 1, 4'b1111, 0, 1, 4'b0001, 4, 0);
        add("after_pop",   0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 3, 0);
        // Pushes 0001,0010,0100,1000,... while popping the older entries first.
        for (int k = 0; k < 8; k++) begin
            logic [3:0] g, h;
            g = 4'(4'b0001 << (k % 4));
            h = (k < 3) ? 4'(4'b0010 << k) : 4'(4'b0001 << ((k - 3) % 4));
            add($sformatf("wrap%0d", k), 0, 1, g, 1, 1, 4'b1111, 1, 1, h, 3, 0);
        end
        add("stall_hold",  0, 0, 4'b0000, 1, 1, 4'b1101, 1, 0, 4'b0010, 3, 0);
        add("stall_go",    0, 0, 4'b0000, 1, 1, 4'b1111, 1, 1, 4'b0010, 3, 0);
        add("drain0100",   0, 0, 4'b0000, 1, 1, 4'b0100, 1, 1, 4'b0100, 2, 0);
        add("drain1000",   0, 0, 4'b0000, 1, 1, 4'b1000, 1, 1, 4'b1000, 1, 0);
        add("idle_c",      0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
        add("orph_rsp",    0, 0, 4'b0000, 1, 1, 4'b1111, 1, 0, 4'b0000, 0, 0);
        add("orph_set",    0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 1);
        add("orph_push",   0, 1, 4'b0100, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 1);
        add("orph_route",  0, 0, 4'b0000, 1, 1, 4'b1111, 1, 1, 4'b0100, 1, 1);
        add("orph_idle",   0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 1);
        add("s_push0",     0, 1, 4'b0001, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 1);
        add("s_push1",     0, 1, 4'b0010, 0, 0, 4'b0000, 1, 0, 4'b0000, 1, 1);
        add("s_push2",     0, 1, 4'b0100, 0, 0, 4'b0000, 1, 0, 4'b0000, 2, 1);
        add("s_beat_srst", 1, 0, 4'b0000, 1, 0, 4'b1111, 1, 1, 4'b0001, 3, 1);
        add("s_after",     0, 0, 4'b0000, 1, 1, 4'b1111, 1, 0, 4'b0000, 0, 0);
        add("z_push1000",  0, 1, 4'b1000, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 1);
        add("z_push0000",  0, 1, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 1, 1);
        add("z_hold",      0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 1, 1);
        add("z_route",     0, 0, 4'b0000, 1, 1, 4'b1111, 1, 1, 4'b1000, 1, 1);
        add("z_idle",      0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 1);

        drive(0, 0, 4'b0000, 0, 0, 4'b0000);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        foreach (vq[i]) begin
            @(posedge aclk);
            #1 drive(vq[i].srst, vq[i].pv, vq[i].pg, vq[i].rv, vq[i].rl, vq[i].mr);
            @(negedge aclk);
            check(vq[i].name, vq[i].e_pr, vq[i].e_rr, vq[i].e_mv, vq[i].e_out, vq[i].e_orph);
        end

        // Asynchronous reset in the middle of a multi-beat response.
        for (int k = 0; k < 3; k++) begin
            @(posedge aclk);
            #1 drive(0, 1, 4'(4'b0001 << k), 0, 0, 4'b0000);
        end
        @(posedge aclk);
        #1 drive(0, 0, 4'b0000, 1, 0, 4'b1111);
        @(negedge aclk);
        check("a_beat", 1, 1, 4'b0001, 3, 1);
        #1 aresetn = 1'b0;
        #1 check("a_inreset", 1, 0, 4'b0000, 0, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        drive(0, 0, 4'b0000, 0, 0, 4'b1111);
        @(negedge aclk);
        check("a_after", 1, 0, 4'b0000, 0, 0);
        @(posedge aclk);
        #1 drive(0, 1, 4'b0010, 0, 0, 4'b0000);
        @(posedge aclk);
        #1 drive(0, 0, 4'b0000, 1, 1, 4'b0010);
        @(negedge aclk);
        check("a_route", 1, 1, 4'b0010, 1, 0);
        @(posedge aclk);
        #1 drive(0, 0, 4'b0000, 0, 0, 4'b0000);
        @(negedge aclk);
        check("a_idle", 1, 0, 4'b0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
